gs_butterfly_pipe: RTL

- Pipelined Gentleman-Sande butterfly for the ML-KEM inverse NTT (q = 3329).
- Computes a_o = (a+b)/2 mod q and b_o = ((a-b)*zeta)/2 mod q on one coefficient pair per cycle.
- Sits between the INTT coefficient-memory read port and the write-back path.
- Uses valid/ready flow control so the memory scheduler can stall it.

---
 rtl/poly_arith_pkg.sv | 12 +
 rtl/barrett_reduce_24.sv | 21 ++
 rtl/mod_div_by_2.sv | 12 +
 rtl/gs_butterfly_pipe.sv | 99 +++++++++
 4 files changed

// File: rtl/poly_arith_pkg.sv
// Shared arithmetic types and constants for the ML-KEM polynomial datapath.
// Coefficients live in [0, q-1] with q = 3329.
package poly_arith_pkg;

    typedef logic [11:0] coeff_t;
    typedef logic [23:0] prod_t;

    localparam coeff_t      Q         = 12'd3329;
    localparam logic [12:0] BARRETT_M = 13'd5039;
    localparam int          BARRETT_K = 24;

endpackage

// File: rtl/barrett_reduce_24.sv
// Barrett reduction of a 24-bit product to a canonical coefficient.
// The quotient estimate is at most two short, so the remainder fits 14 bits.
module barrett_reduce_24
    import poly_arith_pkg::*;
(
    input  prod_t  prod,
    output coeff_t red
);

    logic [12:0] t;
    logic [13:0] tq;
    logic [13:0] r;
    logic [13:0] r1;

    assign t  = 13'((37'(prod) * 37'(BARRETT_M)) >> BARRETT_K);
    assign tq = 14'(t) * 14'(Q);
    assign r  = prod[13:0] - tq;
    assign r1 = (r >= 14'(Q)) ? r - 14'(Q) : r;
    assign red = (r1 >= 14'(Q)) ? 12'(r1 - 14'(Q)) : 12'(r1);

endmodule

// File: rtl/mod_div_by_2.sv
// Modular halving: x/2 mod q for a canonical x.
// Odd values are made even by adding q before the shift.
module mod_div_by_2
    import poly_arith_pkg::*;
(
    input  coeff_t x,
    output coeff_t y
);

    assign y = x[0] ? 12'(({1'b0, x} + 13'(Q)) >> 1) : (x >> 1);

endmodule

// File: rtl/gs_butterfly_pipe.sv
// Three-stage Gentleman-Sande butterfly for the inverse NTT, q = 3329.
// One global enable stalls every stage when the output is blocked.
module gs_butterfly_pipe
    import poly_arith_pkg::*;
#(
    parameter bit HALVE_EN = 1'b1
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   valid_i,
    output logic   ready_o,
    input  coeff_t a_i,
    input  coeff_t b_i,
    input  coeff_t zeta_i,
    output logic   valid_o,
    input  logic   ready_i,
    output coeff_t a_o,
    output coeff_t b_o
);

    logic        en;
    logic [12:0] sum_w;
    logic [12:0] diff_w;
    coeff_t      sum_c;
    coeff_t      diff_c;
    prod_t       prod_c;
    coeff_t      red_c;

    logic   s1_v;
    coeff_t s1_sum;
    coeff_t s1_diff;
    coeff_t s1_zeta;

    logic   s2_v;
    coeff_t s2_sum;
    prod_t  s2_prod;

    logic   s3_v;
    coeff_t s3_sum;
    coeff_t s3_red;

    assign en      = !s3_v || ready_i;
    assign ready_o = en;
    assign valid_o = s3_v;

    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    assign sum_c  = (sum_w >= 13'(Q)) ? 12'(sum_w - 13'(Q)) : sum_w[11:0];
    // Bit 12 is the borrow of the 13-bit subtraction.
    assign diff_w = {1'b0, a_i} - {1'b0, b_i};
    assign diff_c = diff_w[12] ? 12'(diff_w + 13'(Q)) : diff_w[11:0];
    assign prod_c = prod_t'(s1_diff) * prod_t'(s1_zeta);

    barrett_reduce_24 u_barrett (
        .prod (s2_prod),
        .red  (red_c)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v    <= 1'b0;
            s1_sum  <= '0;
            s1_diff <= '0;
            s1_zeta <= '0;
            s2_v    <= 1'b0;
            s2_sum  <= '0;
            s2_prod <= '0;
            s3_v    <= 1'b0;
            s3_sum  <= '0;
            s3_red  <= '0;
        end else if (en) begin
            s1_v    <= valid_i;
            s1_sum  <= sum_c;
            s1_diff <= diff_c;
            s1_zeta <= zeta_i;
            s2_v    <= s1_v;
            s2_sum  <= s1_sum;
            s2_prod <= prod_c;
            s3_v    <= s2_v;
            s3_sum  <= s2_sum;
            s3_red  <= red_c;
        end
    end

    // Raw outputs leave the final n^-1 scaling to a later pass.
    if (HALVE_EN) begin : g_halve
        mod_div_by_2 u_half_a (
            .x (s3_sum),
            .y (a_o)
        );
        mod_div_by_2 u_half_b (
            .x (s3_red),
            .y (b_o)
        );
    end else begin : g_raw
        assign a_o = s3_sum;
        assign b_o = s3_red;
    end

endmodule
